// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory.
//
//   req    master -> slave  fetch request, held until the ack cycle
//   addr   master -> slave  fetch address, stable while req is high
//   ack    slave  -> master response valid; rdata is valid in the same cycle
//   rdata  slave  -> master fetched instruction word
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ack;
  logic [ADDR_WIDTH-1:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Program counter and instruction-fetch stage. Holds the architectural PC,
// fetches from instruction memory over a req/ack bus, delivers each fetched
// instruction downstream under a valid/stall handshake, and redirects to the
// branch adder's target on a taken branch, discarding wrong-path data.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-low reset
//   stall         downstream not ready; delivered instruction is held
//   branch_taken  single-cycle redirect pulse
//   branch_addr   redirect target
//   imem          fetch_unit_if.master (req/addr out, ack/rdata in)
//   pc            address being fetched or held
//   inst          delivered instruction
//   inst_valid    inst holds a valid instruction
//   misalign      (FETCH_ALIGN_CHECK_EN only) one-cycle pulse after an odd
//                 branch target was loaded with bit0 cleared
//
// Build option: define FETCH_ALIGN_CHECK_EN to force branch targets even and
// add the misalign output.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned                 INST_ADDR_WIDTH   = 16,
  parameter int unsigned                 NUM_BYTES_IN_INST = 2,
  parameter logic [INST_ADDR_WIDTH-1:0]  RESET_ADDR        = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [INST_ADDR_WIDTH-1:0] branch_addr,
  fetch_unit_if.master               imem,
  output logic [INST_ADDR_WIDTH-1:0] pc,
  output logic [INST_ADDR_WIDTH-1:0] inst,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic                       misalign,
`endif
  output logic                       inst_valid
);

  localparam logic [1:0] S_FETCH = 2'd0;  // request outstanding, data wanted
  localparam logic [1:0] S_HOLD  = 2'd1;  // instruction waiting downstream
  localparam logic [1:0] S_FLUSH = 2'd2;  // finishing a wrong-path request

  localparam logic [INST_ADDR_WIDTH-1:0] PC_INC = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);

  logic [1:0]                 state_reg, state_next;
  logic [INST_ADDR_WIDTH-1:0] pc_reg;
  logic [INST_ADDR_WIDTH-1:0] inst_reg;
  logic [INST_ADDR_WIDTH-1:0] redirect_reg;
  logic                       inst_valid_reg, inst_valid_next;
  logic [INST_ADDR_WIDTH-1:0] branch_tgt;

  // Decisions taken this cycle; the register block applies them.
  logic load_branch;       // pc <= branch target
  logic load_redirect;     // pc <= saved redirect target
  logic load_inc;          // pc <= pc + increment
  logic capture_redirect;  // save branch target for the end of a flush
  logic capture_inst;      // latch imem rdata into inst

`ifdef FETCH_ALIGN_CHECK_EN
  assign branch_tgt = {branch_addr[INST_ADDR_WIDTH-1:1], 1'b0};
`else
  assign branch_tgt = branch_addr;
`endif

  // The request must not glitch on while reset is held, so rst gates it
  // combinationally rather than waiting for the next edge.
  assign imem.req   = rst && (state_reg != S_HOLD);
  assign imem.addr  = pc_reg;
  assign pc         = pc_reg;
  assign inst       = inst_reg;
  assign inst_valid = inst_valid_reg;

  always_comb begin
    state_next       = state_reg;
    inst_valid_next  = inst_valid_reg;
    load_branch      = 1'b0;
    load_redirect    = 1'b0;
    load_inc         = 1'b0;
    capture_redirect = 1'b0;
    capture_inst     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (imem.ack) begin
          if (branch_taken) begin
            // Response belongs to the wrong path; refetch at the target.
            load_branch = 1'b1;
          end else begin
            capture_inst    = 1'b1;
            inst_valid_next = 1'b1;
            load_inc        = 1'b1;
            state_next      = S_HOLD;
          end
        end else if (branch_taken) begin
          // The request must stay stable until acked, so park the target.
          capture_redirect = 1'b1;
          state_next       = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (imem.ack) begin
          // A branch in the ack cycle is newer than the saved redirect.
          if (branch_taken) load_branch = 1'b1;
          else              load_redirect = 1'b1;
          state_next = S_FETCH;
        end else if (branch_taken) begin
          capture_redirect = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          inst_valid_next = 1'b0;
          load_branch     = 1'b1;
          state_next      = S_FETCH;
        end else if (!stall) begin
          inst_valid_next = 1'b0;
          state_next      = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_FETCH;
      pc_reg         <= RESET_ADDR;
      inst_reg       <= '0;
      inst_valid_reg <= 1'b0;
      redirect_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      inst_valid_reg <= inst_valid_next;
      if (capture_redirect) redirect_reg <= branch_tgt;
      if (capture_inst)     inst_reg     <= imem.rdata;
      if (load_branch)        pc_reg <= branch_tgt;
      else if (load_redirect) pc_reg <= redirect_reg;
      else if (load_inc)      pc_reg <= pc_reg + PC_INC;  // wraps modulo 2^W
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Remember whether the parked redirect target was odd so the pulse can be
  // raised when it is finally loaded, not when it was captured.
  logic redirect_odd_reg;
  logic misalign_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      redirect_odd_reg <= 1'b0;
      misalign_reg     <= 1'b0;
    end else begin
      if (capture_redirect) redirect_odd_reg <= branch_addr[0];
      misalign_reg <= (load_branch && branch_addr[0]) ||
                      (load_redirect && redirect_odd_reg);
    end
  end

  assign misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed stimulus acting as instruction memory and downstream stage.
// Every acked fetch that should be delivered pushes its expected word into a
// scoreboard queue; a monitor pops and compares on each new inst_valid.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_addr;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign;
`endif

  fetch_unit_if #(.ADDR_WIDTH(16)) imem_bus ();

  fetch_unit #(
    .INST_ADDR_WIDTH  (16),
    .NUM_BYTES_IN_INST(2),
    .RESET_ADDR       (16'h0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem        (imem_bus),
    .pc          (pc),
    .inst        (inst),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign    (misalign),
`endif
    .inst_valid  (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [15:0] sb_q[$];
  logic        prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] actual,
                          input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Instruction memory contents: an arbitrary but address-dependent word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hA53C;
  endfunction

  // Scoreboard monitor: a new instruction appears as a rising inst_valid.
  always @(negedge clk) begin
    if (rst === 1'b1 && inst_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_valid", 16'(inst_valid), 16'h0000);
      end else begin
        logic [15:0] exp_w;
        exp_w = sb_q.pop_front();
        check_eq("sb_inst", inst, exp_w);
        $display("[%0t] deliver inst=0x%04h expected=0x%04h", $time, inst, exp_w);
      end
    end
    prev_valid = inst_valid;
  end

  // Hold reset for three cycles with a toggling ack; nothing may leak out.
  task automatic reset_check();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      imem_bus.ack   = (i % 2 == 0);
      imem_bus.rdata = 16'($urandom);
      @(negedge clk);
      check_eq("rst_req",   16'(imem_bus.req), 16'h0000);
      check_eq("rst_valid", 16'(inst_valid),   16'h0000);
      check_eq("rst_pc",    pc,                16'h0000);
    end
    imem_bus.ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Ack tied high, no stall: one instruction every two cycles. Entered and
  // left at a negedge in the fetch state with inst_valid low.
  task automatic run_stream(input int n, input logic [15:0] start_addr);
    logic [15:0] a;
    a = start_addr;
    imem_bus.ack = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 2 * n; i++) begin
      check_eq("stream_valid", 16'(inst_valid), 16'(i % 2));
      if (i % 2 == 0) begin
        check_eq("stream_req",  16'(imem_bus.req), 16'h0001);
        check_eq("stream_addr", imem_bus.addr, a);
        imem_bus.rdata = mem_word(a);
        sb_q.push_back(mem_word(a));
        a = a + 16'd2;
      end else begin
        check_eq("stream_req_idle", 16'(imem_bus.req), 16'h0000);
      end
      @(negedge clk);
    end
    imem_bus.ack = 1'b0;
  endtask

  // Ack and branch together in the fetch state: response dropped, PC moves.
  task automatic redirect_to(input logic [15:0] target);
    branch_taken   = 1'b1;
    branch_addr    = target;
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 16'hDEAD;
    @(negedge clk);
    branch_taken = 1'b0;
    imem_bus.ack = 1'b0;
    check_eq("redir_pc",    pc,               target);
    check_eq("redir_valid", 16'(inst_valid),  16'h0000);
    check_eq("redir_req",   16'(imem_bus.req), 16'h0001);
  endtask

  initial begin
    rst            = 1'b0;
    stall          = 1'b0;
    branch_taken   = 1'b0;
    branch_addr    = 16'h0000;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 16'h0000;

    // Reset state, with ack activity ignored.
    reset_check();
    check_eq("reset_inst", inst, 16'h0000);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("reset_misalign", 16'(misalign), 16'h0000);
`endif

    // Sequential stream from the reset address.
    run_stream(3, 16'h0000);

    // Stall holds the delivered instruction and blocks new requests.
    redirect_to(16'h0010);
    check_eq("stall_addr", imem_bus.addr, 16'h0010);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = mem_word(16'h0010);
    sb_q.push_back(mem_word(16'h0010));
    stall = 1'b1;
    @(negedge clk);
    imem_bus.ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_valid", 16'(inst_valid),   16'h0001);
      check_eq("stall_inst",  inst,              mem_word(16'h0010));
      check_eq("stall_req",   16'(imem_bus.req), 16'h0000);
      if (i < 3) @(negedge clk);
    end
    stall = 1'b0;
    @(negedge clk);
    check_eq("unstall_req",   16'(imem_bus.req), 16'h0001);
    check_eq("unstall_addr",  imem_bus.addr,     16'h0012);
    check_eq("unstall_valid", 16'(inst_valid),   16'h0000);

    // Two branches during a slow fetch; the newest target wins, old data dropped.
    redirect_to(16'h0020);
    branch_taken = 1'b1;
    branch_addr  = 16'h0100;
    @(negedge clk);
    check_eq("flush_addr1", imem_bus.addr,     16'h0020);
    check_eq("flush_req1",  16'(imem_bus.req), 16'h0001);
    branch_addr = 16'h0200;
    @(negedge clk);
    branch_taken = 1'b0;
    check_eq("flush_addr2", imem_bus.addr,     16'h0020);
    @(negedge clk);
    check_eq("flush_addr3", imem_bus.addr,     16'h0020);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = mem_word(16'h0020);
    @(negedge clk);
    imem_bus.ack = 1'b0;
    check_eq("flush_target", imem_bus.addr,    16'h0200);
    check_eq("flush_valid",  16'(inst_valid),  16'h0000);

    // Branch in the flush ack cycle overrides the saved redirect.
    branch_taken = 1'b1;
    branch_addr  = 16'h0280;
    @(negedge clk);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = mem_word(16'h0200);
    branch_addr    = 16'h0300;
    @(negedge clk);
    branch_taken = 1'b0;
    imem_bus.ack = 1'b0;
    check_eq("flush_ack_branch", imem_bus.addr, 16'h0300);

    // Branch while holding under stall takes priority over the stall.
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = mem_word(16'h0300);
    sb_q.push_back(mem_word(16'h0300));
    stall = 1'b1;
    @(negedge clk);
    imem_bus.ack = 1'b0;
    check_eq("hold_valid", 16'(inst_valid), 16'h0001);
    branch_taken = 1'b1;
    branch_addr  = 16'h0040;
    @(negedge clk);
    branch_taken = 1'b0;
    stall = 1'b0;
    check_eq("hold_br_valid", 16'(inst_valid),   16'h0000);
    check_eq("hold_br_req",   16'(imem_bus.req), 16'h0001);
    check_eq("hold_br_addr",  imem_bus.addr,     16'h0040);

    // PC wraps from 0xFFFE to 0x0000.
    redirect_to(16'hFFFE);
    run_stream(2, 16'hFFFE);
    check_eq("wrap_pc", pc, 16'h0002);

    // Reset with a request outstanding abandons it.
    @(negedge clk);
    reset_check();
    run_stream(2, 16'h0000);

`ifdef FETCH_ALIGN_CHECK_EN
    // Odd branch target is loaded even, with a one-cycle misalign pulse.
    redirect_to(16'h0030);
    check_eq("align_quiet", 16'(misalign), 16'h0000);
    branch_taken = 1'b1;
    branch_addr  = 16'h0031;
    imem_bus.ack = 1'b1;
    @(negedge clk);
    branch_taken = 1'b0;
    imem_bus.ack = 1'b0;
    check_eq("align_addr",  imem_bus.addr,  16'h0030);
    check_eq("align_pulse", 16'(misalign),  16'h0001);
    @(negedge clk);
    check_eq("align_clear", 16'(misalign),  16'h0000);
`endif

    @(negedge clk);
    check_eq("sb_drain", 16'(sb_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
